ram_1r1w_fifo_ctrl: RTL and testbench

//  Valid/ready FIFO controller that sequences an external ram_1r1w_sync instance (1-cycle read latency).

---
 rtl/ram_1r1w_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_ram_1r1w_fifo_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1r1w_fifo_ctrl.sv
// rtl/ram_1r1w_fifo_ctrl.sv - valid/ready FIFO controller driving an external 1R1W sync RAM
// Read latency of the RAM is hidden behind a 2-entry skid buffer so the queue sustains one entry per cycle.
module ram_1r1w_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 3)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              enq_val,
  input  logic [DATA_W-1:0] enq_data,
  output logic              enq_rdy,
  output logic              deq_val,
  output logic [DATA_W-1:0] deq_data,
  input  logic              deq_rdy,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int RCNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [RCNT_W-1:0] ram_cnt, ram_cnt_n;
  logic              rd_inflight;
  logic [1:0]        skid_cnt, skid_cnt_n;
  logic [DATA_W-1:0] skid0, skid1;
  logic              enq_xfer, deq_xfer, push;
  logic [2:0]        pend;

  assign enq_rdy     = (ram_cnt < RCNT_W'(DEPTH)) & ~flush & ~rst;
  assign enq_xfer    = enq_val & enq_rdy;
  assign deq_val     = (skid_cnt != 2'd0);
  assign deq_data    = skid0;
  assign deq_xfer    = deq_val & deq_rdy;
  assign push        = rd_inflight;

  // Entries that will sit in the skid after this edge if no new read is issued.
  assign pend        = {1'b0, skid_cnt} + {2'b0, rd_inflight} - {2'b0, deq_xfer};
  assign ram_rd_en   = (ram_cnt != '0) & (pend < 3'd2) & ~flush;
  assign ram_rd_addr = rd_ptr;
  assign ram_wr_en   = enq_xfer;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = enq_data;

  always_comb begin
    ram_cnt_n  = ram_cnt;
    skid_cnt_n = skid_cnt;
    if (enq_xfer & ~ram_rd_en)      ram_cnt_n = ram_cnt + 1'b1;
    else if (~enq_xfer & ram_rd_en) ram_cnt_n = ram_cnt - 1'b1;
    if (push & ~deq_xfer)           skid_cnt_n = skid_cnt + 2'd1;
    else if (~push & deq_xfer)      skid_cnt_n = skid_cnt - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      skid_cnt    <= 2'd0;
      skid0       <= '0;
      skid1       <= '0;
      occupancy   <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      skid_cnt    <= 2'd0;
      occupancy   <= '0;
    end else begin
      if (enq_xfer)
        wr_ptr <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (ram_rd_en)
        rd_ptr <= (rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      ram_cnt     <= ram_cnt_n;
      rd_inflight <= ram_rd_en;
      skid_cnt    <= skid_cnt_n;
      occupancy   <= CNT_W'(ram_cnt_n) + CNT_W'(ram_rd_en) + CNT_W'(skid_cnt_n);
      if (push) begin
        if (skid_cnt == 2'd0 || (skid_cnt == 2'd1 && deq_xfer)) begin
          skid0 <= ram_rd_data;
        end else if (skid_cnt == 2'd1) begin
          skid1 <= ram_rd_data;
        end else begin
          skid0 <= skid1;
          skid1 <= ram_rd_data;
        end
      end else if (deq_xfer && skid_cnt == 2'd2) begin
        skid0 <= skid1;
      end
    end
  end

  a_no_skid_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && skid_cnt == 2'd2 && !deq_xfer));

endmodule

// File: tb/tb_ram_1r1w_fifo_ctrl.sv
// tb/tb_ram_1r1w_fifo_ctrl.sv - scoreboard bench for ram_1r1w_fifo_ctrl at DEPTH=4 and DEPTH=5
module tb_ram_1r1w_fifo_ctrl;
  logic clk = 0;
  always #5 clk = ~clk;

  logic       rst = 1, flush = 0, enq_val = 0, deq_rdy = 0;
  logic [7:0] enq_data = 0;
  logic       sel = 1;

  logic       enq_rdy4, deq_val4, wr_en4, rd_en4;
  logic [7:0] deq_data4, wr_data4, rd_data4;
  logic [1:0] wr_addr4, rd_addr4;
  logic [2:0] occ4;
  logic       enq_rdy5, deq_val5, wr_en5, rd_en5;
  logic [7:0] deq_data5, wr_data5, rd_data5;
  logic [2:0] wr_addr5, rd_addr5;
  logic [2:0] occ5;

  ram_1r1w_fifo_ctrl #(.DATA_W(8), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .enq_val(enq_val), .enq_data(enq_data), .enq_rdy(enq_rdy4),
    .deq_val(deq_val4), .deq_data(deq_data4), .deq_rdy(deq_rdy), .ram_wr_en(wr_en4),
    .ram_wr_addr(wr_addr4), .ram_wr_data(wr_data4), .ram_rd_en(rd_en4), .ram_rd_addr(rd_addr4),
    .ram_rd_data(rd_data4), .occupancy(occ4));

  ram_1r1w_fifo_ctrl #(.DATA_W(8), .DEPTH(5)) u5 (
    .clk(clk), .rst(rst), .flush(flush), .enq_val(enq_val), .enq_data(enq_data), .enq_rdy(enq_rdy5),
    .deq_val(deq_val5), .deq_data(deq_data5), .deq_rdy(deq_rdy), .ram_wr_en(wr_en5),
    .ram_wr_addr(wr_addr5), .ram_wr_data(wr_data5), .ram_rd_en(rd_en5), .ram_rd_addr(rd_addr5),
    .ram_rd_data(rd_data5), .occupancy(occ5));

  logic [7:0] mem4 [4];
  logic [7:0] mem5 [5];
  always @(posedge clk) begin
    if (wr_en4) mem4[wr_addr4] <= wr_data4;
    if (rd_en4) rd_data4 <= mem4[rd_addr4];
    if (wr_en5) mem5[wr_addr5] <= wr_data5;
    if (rd_en5) rd_data5 <= mem5[rd_addr5];
  end

  logic       enq_rdy_m, deq_val_m, wr_en_m, rd_en_m;
  logic [7:0] deq_data_m, wr_data_m;
  logic [2:0] wr_addr_m, rd_addr_m, occ_m;
  int         dep_m;
  always_comb begin
    enq_rdy_m  = sel ? enq_rdy5 : enq_rdy4;
    deq_val_m  = sel ? deq_val5 : deq_val4;
    deq_data_m = sel ? deq_data5 : deq_data4;
    wr_en_m    = sel ? wr_en5 : wr_en4;
    wr_data_m  = sel ? wr_data5 : wr_data4;
    rd_en_m    = sel ? rd_en5 : rd_en4;
    wr_addr_m  = sel ? wr_addr5 : {1'b0, wr_addr4};
    rd_addr_m  = sel ? rd_addr5 : {1'b0, rd_addr4};
    occ_m      = sel ? occ5 : occ4;
    dep_m      = sel ? 5 : 4;
  end

  int n_checks = 0, n_pass = 0;
  logic [7:0] exp_q[$];
  int exp_waddr = 0, exp_raddr = 0;
  int cyc = 0, first_deq = 0, last_deq = 0, n_deq = 0;
  bit seen_deq = 0, rnd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rnd) deq_rdy = 1'($urandom_range(0, 1));
  end

  // Producer side of the scoreboard: every accepted enq becomes an expected deq.
  initial forever begin
    @(negedge clk);
    if (!rst && enq_val && enq_rdy_m) begin
      chk("wr_en", wr_en_m, 1);
      chk("wr_addr", wr_addr_m, exp_waddr);
      chk("wr_data", wr_data_m, enq_data);
      exp_q.push_back(enq_data);
      exp_waddr = (exp_waddr == dep_m - 1) ? 0 : exp_waddr + 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rd_en_m) begin
        chk("rd_addr", rd_addr_m, exp_raddr);
        exp_raddr = (exp_raddr == dep_m - 1) ? 0 : exp_raddr + 1;
        if (wr_en_m) chk("rw_same_addr", rd_addr_m != wr_addr_m, 1);
      end
      if (deq_val_m && deq_rdy) begin
        if (exp_q.size() == 0) chk("deq_unexpected", deq_data_m, 32'hFFFF_FFFF);
        else chk("deq_data", deq_data_m, exp_q.pop_front());
        if (!seen_deq) first_deq = cyc;
        seen_deq = 1;
        last_deq = cyc;
        n_deq++;
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    exp_waddr = 0;
    exp_raddr = 0;
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; enq_val = 0; rnd = 0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("enq_rdy_in_rst", enq_rdy_m, 0);
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic push(input logic [7:0] d, input int bound, output bit ok);
    ok = 0;
    @(posedge clk); #1;
    enq_val = 1; enq_data = d;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk);
      if (enq_rdy_m) ok = 1;
      else if (k < bound - 1) begin @(posedge clk); #1; end
    end
    if (!ok) enq_val = 0;
  endtask

  task automatic idle();
    @(posedge clk); #1 enq_val = 0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin @(negedge clk); k++; end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // 1: single entry latency
    sel = 1;
    do_reset();
    @(negedge clk);
    chk("rst_occ", occ_m, 0);
    chk("rst_deq_val", deq_val_m, 0);
    chk("rst_deq_data", deq_data_m, 0);
    chk("rst_enq_rdy", enq_rdy_m, 1);
    chk("rst_rd_en", rd_en_m, 0);
    @(posedge clk); #1 enq_val = 1; enq_data = 8'hA5; deq_rdy = 1;
    @(negedge clk); chk("t1_wr_en", wr_en_m, 1); chk("t1_rd_en0", rd_en_m, 0);
    @(posedge clk); #1 enq_val = 0;
    @(negedge clk); chk("t1_rd_en", rd_en_m, 1); chk("t1_deq_val1", deq_val_m, 0);
    @(negedge clk); chk("t1_deq_val2", deq_val_m, 0);
    @(negedge clk); chk("t1_deq_val3", deq_val_m, 1); chk("t1_deq_data", deq_data_m, 8'hA5);
    drain("t1_drain");

    // 2: DEPTH=4 fills to DEPTH+2 with consumer stalled
    sel = 0; deq_rdy = 0;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      push(8'(i), 10, ok);
      chk("t2_accept", ok, 1);
    end
    push(8'd7, 6, ok);
    chk("t2_reject7", ok, 0);
    chk("t2_enq_rdy", enq_rdy_m, 0);
    chk("t2_occ", occ_m, 6);
    @(posedge clk); #1 deq_rdy = 1;
    drain("t2_drain");
    @(negedge clk); chk("t2_occ_empty", occ_m, 0);

    // 3: DEPTH=5 back-to-back stream, pointer wrap, full throughput
    sel = 1; deq_rdy = 1;
    do_reset();
    seen_deq = 0; n_deq = 0;
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h40 + i), 1, ok);
      chk("t3_accept", ok, 1);
    end
    idle();
    drain("t3_drain");
    chk("t3_n_deq", n_deq, 20);
    chk("t3_span", last_deq - first_deq, 19);

    // 4: random consumer stalls
    do_reset();
    rnd = 1;
    for (int i = 0; i < 1000; i++) begin
      push(8'((i * 7 + 3) & 8'hFF), 60, ok);
      chk("t4_accept", ok, 1);
    end
    idle();
    rnd = 0;
    @(posedge clk); #1 deq_rdy = 1;
    drain("t4_drain");

    // 5: flush with a read in flight and a competing enq
    do_reset();
    deq_rdy = 0;
    @(posedge clk); #1 enq_val = 1; enq_data = 8'h11;
    @(negedge clk);
    @(posedge clk); #1 enq_val = 0;
    @(negedge clk); chk("t5_rd_issue", rd_en_m, 1);
    @(posedge clk); #1 flush = 1; enq_val = 1; enq_data = 8'h77; deq_rdy = 1;
    @(negedge clk); chk("t5_enq_rdy_flush", enq_rdy_m, 0); chk("t5_rd_en_flush", rd_en_m, 0);
    @(posedge clk); #1 flush = 0; enq_val = 0;
    clear_model();
    @(negedge clk); chk("t5_deq_val", deq_val_m, 0); chk("t5_occ", occ_m, 0);
    repeat (3) begin @(negedge clk); chk("t5_stale", deq_val_m, 0); end
    push(8'h3C, 4, ok);
    chk("t5_accept", ok, 1);
    idle();
    drain("t5_drain");

    // 6: async reset between edges
    do_reset();
    deq_rdy = 0;
    for (int i = 0; i < 3; i++) push(8'(8'h90 + i), 4, ok);
    idle();
    repeat (4) @(negedge clk);
    chk("t6_pre_deq_val", deq_val_m, 1);
    chk("t6_pre_occ", occ_m, 3);
    @(posedge clk); #3 rst = 1;
    #1;
    chk("t6_async_deq_val", deq_val_m, 0);
    chk("t6_async_occ", occ_m, 0);
    chk("t6_async_enq_rdy", enq_rdy_m, 0);
    chk("t6_async_deq_data", deq_data_m, 0);
    clear_model();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t6_post_deq_val", deq_val_m, 0);
    chk("t6_post_enq_rdy", enq_rdy_m, 1);
    deq_rdy = 1;
    push(8'h5A, 1, ok);
    chk("t6_first_enq", ok, 1);
    idle();
    drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
